// File: rtl/lavadora_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lavadora_pkg
// Description : Shared definitions for the coin-operated washer controller:
//               state encoding, default prices/durations and credit evaluation.
// Revision    : 1.0 - initial release
// ============================================================================
package lavadora_pkg;

    // State encoding (3 bits)
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_COBRO   = 3'd1;
    localparam logic [2:0] ST_INSUF   = 3'd2;
    localparam logic [2:0] ST_SECANDO = 3'd3;
    localparam logic [2:0] ST_LAVANDO = 3'd4;
    localparam logic [2:0] ST_PESADO  = 3'd5;

    typedef enum logic [2:0] {
        IDLE    = ST_IDLE,
        COBRO   = ST_COBRO,
        INSUF   = ST_INSUF,
        SECANDO = ST_SECANDO,
        LAVANDO = ST_LAVANDO,
        PESADO  = ST_PESADO
    } estado_t;

    // Default prices (coins) and service durations (clk cycles)
    localparam int PRECIO_SECADO_DEF = 3;
    localparam int PRECIO_LAVADO_DEF = 4;
    localparam int PRECIO_PESADO_DEF = 8;
    localparam int T_SECADO_DEF      = 20;
    localparam int T_LAVADO_DEF      = 30;
    localparam int T_PESADO_DEF      = 45;
    localparam int ANCHO_CREDITO_DEF = 4;
    localparam int ANCHO_TIEMPO_DEF  = 8;

    // Most expensive affordable service, or INSUF when nothing is affordable
    function automatic estado_t evaluar_credito(
        input logic [31:0] credito,
        input logic [31:0] p_secado,
        input logic [31:0] p_lavado,
        input logic [31:0] p_pesado
    );
        if (credito >= p_pesado)      return PESADO;
        else if (credito >= p_lavado) return LAVANDO;
        else if (credito >= p_secado) return SECANDO;
        else                          return INSUF;
    endfunction

endpackage
`default_nettype wire

// File: rtl/controlador_lavadora_if.sv
`default_nettype none
// ============================================================================
// Module      : controlador_lavadora_if
// Description : Payment inputs and service outputs of the washer controller.
//               master = payment/stimulus side, slave = controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface controlador_lavadora_if;
    logic INTRO_MONEDAS;
    logic FINALIZAR_PAGO;
    logic SECADO;
    logic LAVADO;
    logic LAVADO_PESADO;
    logic INSUFICIENTE;

    modport master (
        output INTRO_MONEDAS, FINALIZAR_PAGO,
        input  SECADO, LAVADO, LAVADO_PESADO, INSUFICIENTE
    );

    modport slave (
        input  INTRO_MONEDAS, FINALIZAR_PAGO,
        output SECADO, LAVADO, LAVADO_PESADO, INSUFICIENTE
    );
endinterface
`default_nettype wire

// File: rtl/temporizador_servicio.sv
`default_nettype none
// ============================================================================
// Module      : temporizador_servicio
// Description : Loadable down-counter timing a running service. Holds at zero;
//               fin flags a zero count that is not being reloaded.
// Revision    : 1.0 - initial release
// ============================================================================
module temporizador_servicio #(
    parameter int ANCHO_TIEMPO = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    carga,
    input  logic [ANCHO_TIEMPO-1:0] valor,
    output logic                    fin
);
    logic [ANCHO_TIEMPO-1:0] cuenta_q;
    logic [ANCHO_TIEMPO-1:0] cuenta_d;

    // Next count: load has priority, otherwise count down and stop at zero
    always_comb begin
        cuenta_d = cuenta_q;
        if (carga)
            cuenta_d = valor;
        else if (cuenta_q != '0)
            cuenta_d = cuenta_q - 1'b1;
    end

    // Count register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) cuenta_q <= '0;
        else       cuenta_q <= cuenta_d;
    end

    assign fin = (cuenta_q == '0) && !carga;

endmodule
`default_nettype wire

// File: rtl/controlador_lavadora.sv
`default_nettype none
// ============================================================================
// Module      : controlador_lavadora
// Description : Coin-operated washer controller. Accumulates saturating credit,
//               picks the most expensive affordable service on end-of-payment
//               and runs it for a fixed number of cycles. Outputs registered.
// Revision    : 1.0 - initial release
// ============================================================================
module controlador_lavadora
    import lavadora_pkg::*;
#(
    parameter int PRECIO_SECADO = PRECIO_SECADO_DEF,
    parameter int PRECIO_LAVADO = PRECIO_LAVADO_DEF,
    parameter int PRECIO_PESADO = PRECIO_PESADO_DEF,
    parameter int T_SECADO      = T_SECADO_DEF,
    parameter int T_LAVADO      = T_LAVADO_DEF,
    parameter int T_PESADO      = T_PESADO_DEF,
    parameter int ANCHO_CREDITO = ANCHO_CREDITO_DEF,
    parameter int ANCHO_TIEMPO  = ANCHO_TIEMPO_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    controlador_lavadora_if.slave   bus
);
    estado_t                  estado_q, estado_d;
    logic [ANCHO_CREDITO-1:0] credito_q, credito_d;
    logic [ANCHO_CREDITO-1:0] credito_inc;
    logic [31:0]              credito_ext;
    logic                     secado_q, secado_d;
    logic                     lavado_q, lavado_d;
    logic                     pesado_q, pesado_d;
    logic                     insuf_q, insuf_d;
    logic                     carga;
    logic [ANCHO_TIEMPO-1:0]  valor;
    logic                     fin_servicio;
    logic                     en_servicio_q, en_servicio_d;

    // Saturating increment: a full counter stays full instead of wrapping
    assign credito_inc = (credito_q == '1) ? credito_q : credito_q + 1'b1;
    assign credito_ext = 32'(credito_q);

    // Next state, credit and timer load
    always_comb begin
        estado_d  = estado_q;
        credito_d = credito_q;
        case (estado_q)
            IDLE, COBRO, INSUF: begin
                // End-of-payment wins over a coin on the same edge
                if (bus.FINALIZAR_PAGO) begin
                    estado_d = evaluar_credito(credito_ext, 32'(PRECIO_SECADO),
                                               32'(PRECIO_LAVADO), 32'(PRECIO_PESADO));
                end else if (bus.INTRO_MONEDAS) begin
                    estado_d  = COBRO;
                    credito_d = credito_inc;
                end
            end
            SECANDO, LAVANDO, PESADO: begin
                // Payment inputs ignored; leftover credit is consumed at the end
                if (fin_servicio) begin
                    estado_d  = IDLE;
                    credito_d = '0;
                end
            end
            default: begin
                estado_d  = IDLE;
                credito_d = '0;
            end
        endcase

        en_servicio_q = (estado_q == SECANDO) || (estado_q == LAVANDO) || (estado_q == PESADO);
        en_servicio_d = (estado_d == SECANDO) || (estado_d == LAVANDO) || (estado_d == PESADO);

        // Load T-1 on entry so the output stays high exactly T cycles
        carga = en_servicio_d && !en_servicio_q;
        valor = '0;
        case (estado_d)
            SECANDO: valor = ANCHO_TIEMPO'(T_SECADO - 1);
            LAVANDO: valor = ANCHO_TIEMPO'(T_LAVADO - 1);
            PESADO:  valor = ANCHO_TIEMPO'(T_PESADO - 1);
            default: valor = '0;
        endcase

        secado_d = (estado_d == SECANDO);
        lavado_d = (estado_d == LAVANDO);
        pesado_d = (estado_d == PESADO);
        insuf_d  = (estado_d == INSUF);
    end

    // State, credit and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado_q  <= IDLE;
            credito_q <= '0;
            secado_q  <= 1'b0;
            lavado_q  <= 1'b0;
            pesado_q  <= 1'b0;
            insuf_q   <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            credito_q <= credito_d;
            secado_q  <= secado_d;
            lavado_q  <= lavado_d;
            pesado_q  <= pesado_d;
            insuf_q   <= insuf_d;
        end
    end

    temporizador_servicio #(
        .ANCHO_TIEMPO (ANCHO_TIEMPO)
    ) u_temporizador (
        .clk   (clk),
        .reset (reset),
        .carga (carga),
        .valor (valor),
        .fin   (fin_servicio)
    );

    assign bus.SECADO        = secado_q;
    assign bus.LAVADO        = lavado_q;
    assign bus.LAVADO_PESADO = pesado_q;
    assign bus.INSUFICIENTE  = insuf_q;

endmodule
`default_nettype wire

// File: tb/tb_controlador_lavadora.sv
`default_nettype none
// ============================================================================
// Module      : tb_controlador_lavadora
// Description : Self-checking bench for controlador_lavadora. Expected outputs
//               {SECADO,LAVADO,LAVADO_PESADO,INSUFICIENTE} are queued as each
//               vector is driven and compared after the following clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_controlador_lavadora;

    localparam logic [3:0] Z = 4'b0000;
    localparam logic [3:0] S = 4'b1000;
    localparam logic [3:0] L = 4'b0100;
    localparam logic [3:0] P = 4'b0010;
    localparam logic [3:0] I = 4'b0001;

    typedef struct {
        logic       intro;
        logic       fin;
        logic [3:0] exp;
        int         reps;
        string      tag;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    logic [3:0] exp_q[$];
    vec_t vecs[$];

    always #5 clk = ~clk;

    controlador_lavadora_if bus ();

    controlador_lavadora #(
        .PRECIO_SECADO (3),
        .PRECIO_LAVADO (4),
        .PRECIO_PESADO (8),
        .T_SECADO      (20),
        .T_LAVADO      (30),
        .T_PESADO      (45),
        .ANCHO_CREDITO (4),
        .ANCHO_TIEMPO  (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic logic [3:0] salidas();
        return {bus.SECADO, bus.LAVADO, bus.LAVADO_PESADO, bus.INSUFICIENTE};
    endfunction

    task automatic comparar(input string tag);
        logic [3:0] e;
        logic [3:0] g;
        e = exp_q.pop_front();
        g = salidas();
        checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL %s: got %b expected %b (S L P I) at %0t", tag, g, e, $time);
        end
    endtask

    task automatic paso(input logic intro, input logic fin, input logic [3:0] exp,
                        input string tag);
        @(negedge clk);
        bus.INTRO_MONEDAS  = intro;
        bus.FINALIZAR_PAGO = fin;
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        comparar(tag);
    endtask

    task automatic add(input logic intro, input logic fin, input logic [3:0] exp,
                       input int reps, input string tag);
        vec_t v;
        v.intro = intro;
        v.fin   = fin;
        v.exp   = exp;
        v.reps  = reps;
        v.tag   = tag;
        vecs.push_back(v);
    endtask

    initial begin
        // ---------------- vector table ----------------
        add(0, 0, Z, 10, "idle_after_reset");
        // 2 coins -> insufficient, 2 more -> normal wash (credit 4)
        add(1, 0, Z, 2,  "a_coins");
        add(0, 1, I, 1,  "a_insuf");
        add(0, 0, I, 1,  "a_insuf_hold");
        add(1, 0, Z, 2,  "a_more_coins");
        add(0, 1, L, 1,  "a_lavado_start");
        add(1, 0, L, 29, "a_lavado_run_coins_ignored");
        add(0, 0, Z, 1,  "a_lavado_end");
        // 3 coins -> drying 20 cycles with inputs ignored
        add(1, 0, Z, 3,  "b_coins");
        add(0, 1, S, 1,  "b_secado_start");
        add(1, 1, S, 19, "b_secado_run_inputs_ignored");
        add(0, 0, Z, 1,  "b_secado_end");
        // Next payment restarts from zero credit
        add(1, 0, Z, 2,  "b_fresh_coins");
        add(0, 1, I, 1,  "b_fresh_credit_insuf");
        add(1, 0, Z, 1,  "b_insuf_coin");
        add(0, 1, S, 1,  "b_secado2_start");
        add(0, 0, S, 19, "b_secado2_run");
        add(0, 0, Z, 1,  "b_secado2_end");
        // 4 coins -> wash, 9 coins -> heavy wash
        add(1, 0, Z, 4,  "c_coins4");
        add(0, 1, L, 1,  "c_lavado_start");
        add(0, 0, L, 29, "c_lavado_run");
        add(0, 0, Z, 1,  "c_lavado_end");
        add(1, 0, Z, 9,  "c_coins9");
        add(0, 1, P, 1,  "c_pesado_start");
        add(0, 0, P, 44, "c_pesado_run");
        add(0, 0, Z, 1,  "c_pesado_end");
        // 20 coins saturate at 15 (a wrap would give 4 -> wash)
        add(1, 0, Z, 20, "d_coins20");
        add(0, 1, P, 1,  "d_sat_pesado_start");
        add(0, 0, P, 44, "d_sat_pesado_run");
        add(0, 0, Z, 1,  "d_sat_pesado_end");
        // Coin and end-of-payment together: coin not counted -> credit 3
        add(1, 0, Z, 3,  "d_coins3");
        add(1, 1, S, 1,  "d_simul_secado");
        add(0, 0, S, 19, "d_simul_run");
        add(0, 0, Z, 1,  "d_simul_end");
        // End-of-payment from idle with no credit, re-evaluation in INSUF
        add(0, 1, I, 1,  "e_idle_fin_insuf");
        add(0, 0, I, 1,  "e_insuf_hold");
        add(0, 1, I, 1,  "e_insuf_reeval");
        add(1, 0, Z, 1,  "e_insuf_coin_clears");

        // ---------------- reset ----------------
        reset = 1'b1;
        bus.INTRO_MONEDAS  = 1'b0;
        bus.FINALIZAR_PAGO = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        exp_q.push_back(Z);
        comparar("reset_hold");
        @(negedge clk);
        reset = 1'b0;

        // ---------------- table ----------------
        foreach (vecs[k]) begin
            for (int r = 0; r < vecs[k].reps; r++)
                paso(vecs[k].intro, vecs[k].fin, vecs[k].exp, vecs[k].tag);
        end

        // ---------------- async reset during heavy wash ----------------
        for (int n = 0; n < 9; n++) paso(1, 0, Z, "f_coins");
        paso(0, 1, P, "f_pesado_start");
        for (int n = 0; n < 9; n++) paso(0, 0, P, "f_pesado_run");
        @(negedge clk);
        bus.INTRO_MONEDAS  = 1'b0;
        bus.FINALIZAR_PAGO = 1'b0;
        #2;
        reset = 1'b1;
        exp_q.push_back(Z);
        #1;
        comparar("f_async_reset_no_edge");
        @(negedge clk);
        reset = 1'b0;
        for (int n = 0; n < 4; n++) paso(1, 0, Z, "f_post_reset_coins");
        paso(0, 1, L, "f_post_reset_lavado");
        for (int n = 0; n < 29; n++) paso(0, 0, L, "f_post_reset_run");
        paso(0, 0, Z, "f_post_reset_end");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
